// File: rtl/comp_pkg.sv
// Shared definitions for the bit-serial comparator controller.
package comp_pkg;

  // Controller states; the encodings are fixed so waveforms and other users agree on them.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Result vector ordering is {l, e, g}.
  localparam int unsigned RES_W     = 3;
  localparam int unsigned RES_L_BIT = 2;
  localparam int unsigned RES_E_BIT = 1;
  localparam int unsigned RES_G_BIT = 0;

  // Build a result vector in the shared {l, e, g} ordering.
  function automatic logic [RES_W-1:0] pack_res(input logic l, input logic e, input logic g);
    return {l, e, g};
  endfunction

endpackage

// File: rtl/comp_1bit_nor.sv
// Single-bit magnitude comparator cell; e is formed as the NOR of l and g.
module comp_1bit_nor (
  input  logic a,
  input  logic b,
  output logic l,
  output logic e,
  output logic g
);

  assign l = ~a & b;
  assign g = a & ~b;
  assign e = ~(l | g);

endmodule

// File: rtl/comp_serial_ctrl.sv
// Bit-serial WIDTH-bit unsigned comparator: latches operands on start, feeds the 1-bit cell
// MSB first and stops on the first unequal bit, reporting a one-hot {l, e, g} with a done pulse.
module comp_serial_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           r_state, w_state_d;
  logic [WIDTH-1:0] r_a_sh, w_a_sh_d;
  logic [WIDTH-1:0] r_b_sh, w_b_sh_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [RES_W-1:0] r_res, w_res_d;

  logic w_cell_l;
  logic w_cell_e;
  logic w_cell_g;

  // The cell always looks at the current MSBs; the controller has no magnitude logic of its own.
  comp_1bit_nor u_cell (
    .a (r_a_sh[WIDTH-1]),
    .b (r_b_sh[WIDTH-1]),
    .l (w_cell_l),
    .e (w_cell_e),
    .g (w_cell_g)
  );

  // State, shift registers, bit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_d;
      r_a_sh  <= w_a_sh_d;
      r_b_sh  <= w_b_sh_d;
      r_cnt   <= w_cnt_d;
      r_res   <= w_res_d;
    end
  end

  // Next-state logic: accept in IDLE, resolve on first unequal bit or after the LSB.
  always_comb begin
    w_state_d = r_state;
    w_a_sh_d  = r_a_sh;
    w_b_sh_d  = r_b_sh;
    w_cnt_d   = r_cnt;
    w_res_d   = r_res;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_sh_d  = a;
          w_b_sh_d  = b;
          w_cnt_d   = CNT_W'(WIDTH - 1);
          w_res_d   = '0;
          w_state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!w_cell_e) begin
          w_res_d   = pack_res(w_cell_l, 1'b0, w_cell_g);
          w_state_d = ST_DONE;
        end else if (r_cnt == '0) begin
          w_res_d   = pack_res(1'b0, 1'b1, 1'b0);
          w_state_d = ST_DONE;
        end else begin
          w_a_sh_d = {r_a_sh[WIDTH-2:0], 1'b0};
          w_b_sh_d = {r_b_sh[WIDTH-2:0], 1'b0};
          w_cnt_d  = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        // start here is deliberately ignored; it must still be high in IDLE.
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state; results come straight from registers.
  always_comb begin
    busy = (r_state == ST_COMPARE);
    done = (r_state == ST_DONE);
    l    = r_res[RES_L_BIT];
    e    = r_res[RES_E_BIT];
    g    = r_res[RES_G_BIT];
  end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Scoreboard bench for comp_serial_ctrl (WIDTH=8): the driver queues hand-computed results,
// the monitor pops and checks them whenever done is seen.
module tb_comp_serial_ctrl;

  localparam logic [2:0] RL = 3'b100;
  localparam logic [2:0] RE = 3'b010;
  localparam logic [2:0] RG = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       l;
  logic       e;
  logic       g;

  typedef struct {
    logic [2:0]  leg;
    int unsigned cyc;
    int unsigned busy_n;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned busy_run = 0;
  bit          hold_ok = 1'b0;
  logic [2:0]  last_leg = 3'b000;

  comp_serial_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .e     (e),
    .g     (g)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      busy_run = 0;
      hold_ok  = 1'b0;
    end else begin
      if (busy) begin
        busy_run++;
        check("leg_zero_while_busy", {29'd0, l, e, g}, 32'd0);
      end
      if (done) begin
        check("busy_low_in_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with leg %b, expected no done", {l, e, g});
        end else begin
          x = sb.pop_front();
          check("result_leg", {29'd0, l, e, g}, {29'd0, x.leg});
          check("done_cycle", cyc, x.cyc);
          check("busy_cycles", busy_run, x.busy_n);
          last_leg = x.leg;
          hold_ok  = 1'b1;
        end
        busy_run = 0;
      end else if (!busy && hold_ok) begin
        check("result_hold", {29'd0, l, e, g}, {29'd0, last_leg});
      end
    end
  end

  // One-cycle start pulse; expected result and done cycle queued as it is issued.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] leg,
                       input int unsigned lat);
    exp_t x;
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    x.leg    = leg;
    x.cyc    = cyc + lat;
    x.busy_n = lat - 1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    int unsigned c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", {27'd0, busy, done, l, e, g}, 32'd0);
    rst = 1'b0;

    // 1: MSB mismatch -> g at cycle 2; start raised during DONE must be ignored.
    issue(8'h80, 8'h7F, RG, 2);
    @(negedge clk);
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    wait_idle();

    // 2: LSB mismatch -> l at cycle 9.
    issue(8'h12, 8'h13, RL, 9);
    wait_idle();

    // 3: equal then immediate MSB mismatch.
    issue(8'hA5, 8'hA5, RE, 9);
    wait_idle();
    issue(8'h00, 8'hFF, RL, 2);
    wait_idle();

    // 4: second start and operand changes during COMPARE are ignored.
    issue(8'h3C, 8'h3C, RE, 9);
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // 5: async reset in cycle 4 aborts with no done pulse.
    @(negedge clk);
    a     = 8'h55;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", {27'd0, busy, done, l, e, g}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", {27'd0, busy, done, l, e, g}, 32'd0);
    issue(8'h01, 8'h00, RG, 9);
    wait_idle();

    // 6: start held 30 cycles, a=40 b=20 resolves at bit 1 -> done every 4 cycles.
    @(negedge clk);
    c = cyc;
    for (int j = 0; j < 8; j++) begin
      x.leg    = RG;
      x.cyc    = c + 4 * j + 3;
      x.busy_n = 2;
      sb.push_back(x);
    end
    a     = 8'h40;
    b     = 8'h20;
    start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comp_serial_ctrl.md
Name: comp_serial_ctrl

Overview:
Bit-serial magnitude comparator controller for two WIDTH-bit unsigned operands.
- Latches both operands on a start request.
- Feeds one bit pair per clock, MSB first, into a single 1-bit comparator cell (l/e/g outputs).
- Resolves early on the first unequal bit and reports a one-hot less/equal/greater result with a done pulse.
- Lets the existing 1-bit comparator cell serve as a multi-bit compare resource under a start/done handshake.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a comparison; accepted only in IDLE.
a  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
b  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
busy  output  1  high while a comparison is in progress (state COMPARE).
done  output  1  one-cycle pulse; result valid from this cycle onward.
l  output  1  registered result: a < b.
e  output  1  registered result: a == b.
g  output  1  registered result: a > b.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, l, e, g go to 0.
  - Shift registers and bit counter are cleared.
- States: IDLE, COMPARE, DONE.
- IDLE, start=1 at edge 0:
  - Latch a_sh<=a and b_sh<=b.
  - cnt<=WIDTH-1.
  - Clear l/e/g to 0.
  - Go to COMPARE. busy=1 from cycle 1.
- IDLE, start=0: hold state. l/e/g keep the last result.
- COMPARE:
  - The cell inputs are combinationally driven by a_sh[WIDTH-1] and b_sh[WIDTH-1].
  - Cell e=0: register l<=cell_l and g<=cell_g (e stays 0), go to DONE.
  - Cell e=1 and cnt==0: register e<=1, go to DONE.
  - Otherwise: shift a_sh and b_sh left by 1, cnt<=cnt-1, stay in COMPARE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - start during DONE is ignored; it must still be high in IDLE to be accepted.
- Latency, measured from the accepting edge 0:
  - MSB mismatch: done high in cycle 2.
  - Mismatch at bit position k counted from the MSB (k=0..WIDTH-1): done in cycle k+2.
  - Equal operands: done in cycle WIDTH+1.
- Result encoding:
  - Exactly one of l/e/g is 1 from the DONE cycle until the next accepted start.
  - All three are 0 while busy and after reset.
- start held continuously high: a new compare is accepted on every IDLE edge. Back-to-back throughput is one compare per (latency+1) cycles.
- Operand changes while busy: ignored, because operands are latched.
- Reset asserted mid-COMPARE: immediate abort, no done pulse, outputs go to 0.
- No overflow is possible: cnt width is clog2(WIDTH), and cnt never decrements below 0.

Decomposition:
- Shared package (comp_pkg):
  - State encodings ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_DONE=2'd2 as localparams.
  - Result bit ordering constant {l,e,g}.
- One sub-module instance: comp_1bit_nor (existing 1-bit comparator cell, port order a,b,l,e,g). It is the only compare datapath; the controller adds no separate magnitude logic.
- The controller holds the FSM, operand shift registers, bit counter and result registers.

Test Plan (WIDTH=8):
1. a=8'h80, b=8'h7F, start pulse 1 cycle -> busy high cycle 1 only; done in cycle 2 with g=1, l=0, e=0; result holds until the next start.
2. a=8'h12, b=8'h13 -> mismatch at the LSB; done in cycle 9 with l=1; busy high cycles 1-8.
3. a=8'hA5, b=8'hA5 -> done in cycle 9 with e=1; then a=8'h00, b=8'hFF -> done in cycle 2 with l=1; l/e/g all 0 in the busy cycle between.
4. Start a=8'h3C, b=8'h3C; pulse start again and change a/b to 8'hFF/8'h00 during COMPARE -> second start ignored; result e=1 at cycle 9; exactly one done pulse.
5. Start a=8'h55, b=8'h55; assert rst asynchronously mid-cycle at cycle 4 -> busy, l, e, g go to 0 immediately; no done pulse; after release, start a=8'h01, b=8'h00 -> g=1 at cycle 9.
6. start held high for 30 cycles with a=8'h40, b=8'h20 -> done pulses at cycles 3, 7, 11, ... (period 4); g=1 throughout the IDLE/DONE windows.
